// File: rtl/fp_compare_pipe.sv
// Pipelined IEEE 754 compare / minimumNumber / maximumNumber unit.
// The operands are decoded at the input, the magnitude compare is split into halves, and the result is registered at the end.
module fp_compare_pipe #(
  parameter int FPWID  = 80,
  parameter int EXPWID = 15,
  parameter int FMWID  = 64,
  parameter int QBIT   = 62,
  parameter int STAGES = 2,
  parameter int TAGW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [FPWID-1:0] a,
  input  logic [FPWID-1:0] b,
  input  logic [TAGW-1:0]  tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FPWID-1:0] o,
  output logic [TAGW-1:0]  o_tag,
  output logic             nan,
  output logic             snan,
  output logic             inf,
  input  logic             clr_flags,
  output logic             invalid_sticky
);

  localparam int MW = EXPWID + FMWID;
  localparam int LW = MW / 2;

  typedef struct packed {
    logic [FPWID-1:0] a;
    logic [FPWID-1:0] b;
    logic [1:0]       op;
    logic [TAGW-1:0]  tag;
    logic             nan_a;
    logic             nan_b;
    logic             snan;
    logic             inf_a;
    logic             inf_b;
    logic             zero_a;
    logic             zero_b;
  } dec_t;

  typedef struct packed {
    dec_t d;
    logic hi_lt;
    logic hi_eq;
    logic lo_lt;
    logic lo_eq;
  } cmp_t;

  // Valid/ready: a beat moves on a cycle where valid and ready are both high; the
  // whole pipe stalls only while a result sits unaccepted at the output.
  logic             w_adv;
  logic             w_acc;
  logic             w_exp1_a, w_exp1_b, w_manz_a, w_manz_b;
  logic             w_nan_a, w_nan_b;
  dec_t             w_d0, w_d1;
  cmp_t             w_c1, w_c2;
  logic             w_v1, w_v2;
  logic             w_mag_lt, w_mag_eq, w_mag_gt;
  logic             w_sa, w_sb, w_unord, w_eq, w_lt;
  logic             w_a_first, w_b_first;
  logic [FPWID-1:0] w_qnan, w_res;
  logic             r_out_valid, r_nan, r_snan, r_inf, r_sticky;
  logic [FPWID-1:0] r_o;
  logic [TAGW-1:0]  r_tag;

  assign w_adv    = !(r_out_valid && !out_ready);
  assign in_ready = w_adv;
  assign w_acc    = in_valid && w_adv;

  assign w_exp1_a = &a[FPWID-2:FMWID];
  assign w_exp1_b = &b[FPWID-2:FMWID];
  assign w_manz_a = ~|a[FMWID-1:0];
  assign w_manz_b = ~|b[FMWID-1:0];
  assign w_nan_a  = w_exp1_a && !w_manz_a;
  assign w_nan_b  = w_exp1_b && !w_manz_b;

  always_comb begin
    w_d0        = '0;
    w_d0.a      = a;
    w_d0.b      = b;
    w_d0.op     = op;
    w_d0.tag    = tag;
    w_d0.nan_a  = w_nan_a;
    w_d0.nan_b  = w_nan_b;
    w_d0.snan   = (w_nan_a && !a[QBIT]) || (w_nan_b && !b[QBIT]);
    w_d0.inf_a  = w_exp1_a && w_manz_a;
    w_d0.inf_b  = w_exp1_b && w_manz_b;
    w_d0.zero_a = ~|a[FPWID-2:0];
    w_d0.zero_b = ~|b[FPWID-2:0];
  end

  generate
    if (STAGES >= 2) begin : g_s1
      dec_t r_d1;
      logic r_v1;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_v1 <= 1'b0;
          r_d1 <= '0;
        end else if (w_adv) begin
          r_v1 <= w_acc;
          if (w_acc) r_d1 <= w_d0;
        end
      end
      assign w_d1 = r_d1;
      assign w_v1 = r_v1;
    end else begin : g_s1_pass
      assign w_d1 = w_d0;
      assign w_v1 = w_acc;
    end
  endgenerate

  // {exp, man} is compared as two unsigned halves so a 3-stage build can register between them.
  always_comb begin
    w_c1       = '0;
    w_c1.d     = w_d1;
    w_c1.hi_lt = w_d1.a[MW-1:LW] < w_d1.b[MW-1:LW];
    w_c1.hi_eq = w_d1.a[MW-1:LW] == w_d1.b[MW-1:LW];
    w_c1.lo_lt = w_d1.a[LW-1:0] < w_d1.b[LW-1:0];
    w_c1.lo_eq = w_d1.a[LW-1:0] == w_d1.b[LW-1:0];
  end

  generate
    if (STAGES >= 3) begin : g_s2
      cmp_t r_c2;
      logic r_v2;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_v2 <= 1'b0;
          r_c2 <= '0;
        end else if (w_adv) begin
          r_v2 <= w_v1;
          if (w_v1) r_c2 <= w_c1;
        end
      end
      assign w_c2 = r_c2;
      assign w_v2 = r_v2;
    end else begin : g_s2_pass
      assign w_c2 = w_c1;
      assign w_v2 = w_v1;
    end
  endgenerate

  assign w_mag_eq  = w_c2.hi_eq && w_c2.lo_eq;
  assign w_mag_lt  = w_c2.hi_lt || (w_c2.hi_eq && w_c2.lo_lt);
  assign w_mag_gt  = !w_mag_lt && !w_mag_eq;
  assign w_sa      = w_c2.d.a[FPWID-1];
  assign w_sb      = w_c2.d.b[FPWID-1];
  assign w_unord   = w_c2.d.nan_a || w_c2.d.nan_b;
  assign w_eq      = !w_unord && ((w_c2.d.zero_a && w_c2.d.zero_b) || ((w_sa == w_sb) && w_mag_eq));
  // Sign-aware ordering in which -0 sorts below +0; used by both lt and min/max.
  assign w_a_first = (w_sa != w_sb) ? w_sa : (w_sa ? w_mag_gt : w_mag_lt);
  assign w_b_first = (w_sa != w_sb) ? w_sb : (w_sa ? w_mag_lt : w_mag_gt);
  assign w_lt      = !w_unord && !w_eq && w_a_first;

  always_comb begin
    w_qnan                   = '0;
    w_qnan[FPWID-2:FMWID]    = '1;
    w_qnan[QBIT]             = 1'b1;
    if (FMWID == 64) w_qnan[FMWID-1] = 1'b1;
  end

  always_comb begin
    w_res = '0;
    case (w_c2.d.op)
      2'd1: begin
        if (w_c2.d.nan_a && w_c2.d.nan_b) w_res = w_qnan;
        else if (w_c2.d.nan_a)            w_res = w_c2.d.b;
        else if (w_c2.d.nan_b)            w_res = w_c2.d.a;
        else                              w_res = w_b_first ? w_c2.d.b : w_c2.d.a;
      end
      2'd2: begin
        if (w_c2.d.nan_a && w_c2.d.nan_b) w_res = w_qnan;
        else if (w_c2.d.nan_a)            w_res = w_c2.d.b;
        else if (w_c2.d.nan_b)            w_res = w_c2.d.a;
        else                              w_res = w_a_first ? w_c2.d.b : w_c2.d.a;
      end
      default: begin
        w_res[0]  = w_eq;
        w_res[1]  = w_lt;
        w_res[2]  = w_lt || w_eq;
        w_res[3]  = w_mag_lt;
        w_res[4]  = w_unord;
        w_res[8]  = !w_eq;
        w_res[9]  = !w_lt;
        w_res[10] = !(w_lt || w_eq);
        w_res[11] = !w_mag_lt;
        w_res[12] = !w_unord;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_o         <= '0;
      r_tag       <= '0;
      r_nan       <= 1'b0;
      r_snan      <= 1'b0;
      r_inf       <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_v2;
      if (w_v2) begin
        r_o    <= w_res;
        r_tag  <= w_c2.d.tag;
        r_nan  <= w_unord || (w_c2.d.inf_a && w_c2.d.inf_b);
        r_snan <= w_c2.d.snan;
        r_inf  <= w_c2.d.inf_a || w_c2.d.inf_b;
      end
    end
  end

  // Set on a delivered sNaN result takes priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)                                    r_sticky <= 1'b0;
    else if (r_out_valid && out_ready && r_snan) r_sticky <= 1'b1;
    else if (clr_flags)                         r_sticky <= 1'b0;
  end

  assign out_valid      = r_out_valid;
  assign o              = r_o;
  assign o_tag          = r_tag;
  assign nan            = r_nan;
  assign snan           = r_snan;
  assign inf            = r_inf;
  assign invalid_sticky = r_sticky;

endmodule
